// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The step counter must hold the value DD_W, so its width is clog2(DD_W+1).
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        FIX,
        ZERO,
        DONE
    } state_t;

    localparam int DEF_DD_W = 16;
    localparam int DEF_DV_W = 8;

    function automatic int cnt_w(input int dd_w);
        return $clog2(dd_w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// go/done request bundle between a control FSM (master) and seq_divider (slave).
// The remainder signal exists only when DIVIDER_REM_EN is defined.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int DD_W = DEF_DD_W,
    parameter int DV_W = DEF_DV_W
);
    logic            go;
    logic [DD_W-1:0] dd_in;
    logic [DV_W-1:0] dv_in;
    logic            done;
    logic [DD_W-1:0] quotient;
    logic            dz;
`ifdef DIVIDER_REM_EN
    logic [DV_W-1:0] remainder;
`endif

    modport master (
        output go, dd_in, dv_in,
        input  done, quotient, dz
`ifdef DIVIDER_REM_EN
        , input remainder
`endif
    );

    modport slave (
        input  go, dd_in, dv_in,
        output done, quotient, dz
`ifdef DIVIDER_REM_EN
        , output remainder
`endif
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference if non-negative, else restore.
module div_step
    import div_pkg::*;
#(
    parameter int DV_W = DEF_DV_W
) (
    input  logic [DV_W:0]   rem,
    input  logic            dd_bit,
    input  logic [DV_W-1:0] dv_mag,
    output logic [DV_W:0]   rem_next,
    output logic            q_bit
);
    logic [DV_W+1:0] shifted;
    logic [DV_W+1:0] diff;

    always_comb begin
        shifted  = {rem, dd_bit};
        diff     = shifted - {2'b00, dv_mag};
        q_bit    = ~diff[DV_W+1];
        rem_next = q_bit ? diff[DV_W:0] : shifted[DV_W:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider, one quotient bit per clock (restoring algorithm).
// Define DIVIDER_REM_EN to build the signed remainder output and its sign fix.
module seq_divider
    import div_pkg::*;
#(
    parameter int DD_W = DEF_DD_W,
    parameter int DV_W = DEF_DV_W
) (
    input  logic          clk,
    input  logic          reset_L,
    seq_divider_if.slave  bus
);
    localparam int CW = cnt_w(DD_W);

    state_t          state_reg;
    state_t          state_next;
    logic [DD_W-1:0] work_reg;
    logic [DV_W:0]   rem_reg;
    logic [DV_W-1:0] dvm_reg;
    logic            dd_sign_reg;
    logic            dv_sign_reg;
    logic [CW-1:0]   cnt_reg;
    logic            done_reg;
    logic            dz_reg;
    logic [DD_W-1:0] quot_reg;
`ifdef DIVIDER_REM_EN
    logic [DV_W-1:0] rem_out_reg;
`endif

    logic [DD_W-1:0] dd_mag;
    logic [DV_W-1:0] dv_mag;
    logic            dv_zero;
    logic [DV_W:0]   rem_step;
    logic            q_bit;

    assign dd_mag  = bus.dd_in[DD_W-1] ? -bus.dd_in : bus.dd_in;
    assign dv_mag  = bus.dv_in[DV_W-1] ? -bus.dv_in : bus.dv_in;
    assign dv_zero = (bus.dv_in == '0);

    // work_reg shifts dividend bits out of the top while quotient bits enter at the bottom
    div_step #(.DV_W(DV_W)) u_step (
        .rem      (rem_step_src()),
        .dd_bit   (work_reg[DD_W-1]),
        .dv_mag   (dvm_reg),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    function automatic logic [DV_W:0] rem_step_src();
        return rem_reg;
    endfunction

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.go) state_next = dv_zero ? ZERO : ITER;
            ITER: if (cnt_reg == CW'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            ZERO: state_next = DONE;
            DONE: if (!bus.go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            work_reg    <= '0;
            rem_reg     <= '0;
            dvm_reg     <= '0;
            dd_sign_reg <= 1'b0;
            dv_sign_reg <= 1'b0;
            cnt_reg     <= '0;
            done_reg    <= 1'b1;
            dz_reg      <= 1'b0;
            quot_reg    <= '0;
`ifdef DIVIDER_REM_EN
            rem_out_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.go) begin
                        // A zero divisor skips iteration, so keep the raw dividend for the remainder
                        work_reg    <= dv_zero ? bus.dd_in : dd_mag;
                        rem_reg     <= '0;
                        dvm_reg     <= dv_mag;
                        dd_sign_reg <= bus.dd_in[DD_W-1];
                        dv_sign_reg <= bus.dv_in[DV_W-1];
                        cnt_reg     <= CW'(DD_W);
                        done_reg    <= 1'b0;
                        dz_reg      <= 1'b0;
                        quot_reg    <= '0;
`ifdef DIVIDER_REM_EN
                        rem_out_reg <= '0;
`endif
                    end
                end
                ITER: begin
                    work_reg <= {work_reg[DD_W-2:0], q_bit};
                    rem_reg  <= rem_step;
                    cnt_reg  <= cnt_reg - CW'(1);
                end
                FIX: begin
                    quot_reg <= (dd_sign_reg ^ dv_sign_reg) ? -work_reg : work_reg;
`ifdef DIVIDER_REM_EN
                    rem_out_reg <= dd_sign_reg ? -rem_reg[DV_W-1:0] : rem_reg[DV_W-1:0];
`endif
                    done_reg <= 1'b1;
                end
                ZERO: begin
                    quot_reg <= '0;
                    dz_reg   <= 1'b1;
`ifdef DIVIDER_REM_EN
                    rem_out_reg <= work_reg[DV_W-1:0];
`endif
                    done_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done     = done_reg;
    assign bus.quotient = quot_reg;
    assign bus.dz       = dz_reg;
`ifdef DIVIDER_REM_EN
    assign bus.remainder = rem_out_reg;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (DD_W=16, DV_W=8): the driver queues expected
// results, a negedge monitor checks each one when done rises.
module tb_seq_divider;
    localparam int DD_W = 16;
    localparam int DV_W = 8;

    logic clk = 1'b0;
    logic reset_L = 1'b0;

    seq_divider_if #(.DD_W(DD_W), .DV_W(DV_W)) bus ();

    seq_divider #(.DD_W(DD_W), .DV_W(DV_W)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          low;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lowcnt = 0;
    logic prev_done = 1'b1;
    bit   abort_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: measure done-low duration and compare each completed result
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (bus.done !== 1'b1) begin
                lowcnt++;
            end else if (prev_done == 1'b0) begin
                if (abort_pending) begin
                    abort_pending = 1'b0;
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", bus.quotient);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_quotient"}, 32'(bus.quotient), 32'(e.q));
                    chk({e.name, "_dz"}, 32'(bus.dz), 32'(e.dz));
                    chk({e.name, "_done_low"}, 32'(lowcnt), 32'(e.low));
`ifdef DIVIDER_REM_EN
                    chk({e.name, "_remainder"}, 32'(bus.remainder), 32'(e.r));
`endif
                    $display("op %s quotient=%h dz=%b done_low=%0d", e.name, bus.quotient, bus.dz, lowcnt);
                end
                lowcnt = 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=done_low required=done_high", name);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz,
                          input int low, input int hold);
        exp_t e;
        e.name = name; e.q = eq; e.r = er; e.dz = edz; e.low = low;
        sb.push_back(e);
        bus.dd_in = a;
        bus.dv_in = b;
        bus.go    = 1'b1;
        @(negedge clk);
        // Inputs after the accepting edge must not matter
        bus.dd_in = ~a;
        bus.dv_in = b + 8'd1;
        if (hold == 0) bus.go = 1'b0;
        wait_done(name);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({name, "_held_done"}, 32'(bus.done), 32'd1);
            chk({name, "_held_quotient"}, 32'(bus.quotient), 32'(eq));
            bus.go = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.go    = 1'b0;
        bus.dd_in = '0;
        bus.dv_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_done", 32'(bus.done), 32'd1);
        chk("reset_quotient", 32'(bus.quotient), 32'd0);
        chk("reset_dz", 32'(bus.dz), 32'd0);
`ifdef DIVIDER_REM_EN
        chk("reset_remainder", 32'(bus.remainder), 32'd0);
`endif
        reset_L = 1'b1;
        @(negedge clk);

        run_op("p100_p7",    16'd100,   8'd7,   16'd14,   8'd2,   1'b0, 17, 0);
        run_op("n100_p7",   -16'sd100,  8'd7,   16'hFFF2, 8'hFE,  1'b0, 17, 0);
        run_op("p100_n7",    16'd100,  -8'sd7,  16'hFFF2, 8'h02,  1'b0, 17, 0);
        run_op("n100_n7",   -16'sd100, -8'sd7,  16'h000E, 8'hFE,  1'b0, 17, 0);
        run_op("div_zero",   16'd1234,  8'd0,   16'h0000, 8'hD2,  1'b1, 1,  0);
        run_op("ovf_min_n1", 16'h8000,  8'hFF,  16'h8000, 8'h00,  1'b0, 17, 0);
        run_op("max_p1",     16'h7FFF,  8'd1,   16'h7FFF, 8'h00,  1'b0, 17, 0);
        run_op("max_n128",   16'h7FFF,  8'h80,  16'hFF01, 8'h7F,  1'b0, 17, 0);
        run_op("go_held",    16'd500,   8'd3,   16'd166,  8'd2,   1'b0, 17, 42);
        run_op("p9_p4",      16'd9,     8'd4,   16'd2,    8'd1,   1'b0, 17, 0);

        // Abort an operation partway through ITER with an asynchronous reset
        bus.dd_in = 16'd100;
        bus.dv_in = 8'd7;
        bus.go    = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (4) @(negedge clk);
        abort_pending = 1'b1;
        #2 reset_L = 1'b0;
        #1;
        chk("abort_done", 32'(bus.done), 32'd1);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_dz", 32'(bus.dz), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);

        run_op("after_reset", 16'd45, 8'd9, 16'd5, 8'd0, 1'b0, 17, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
